shift_collector: RTL
====================

Name: shift_collector

Overview:
- Serial-to-parallel collector: the receiving end of the shifter's bit-bucket outputs (bb_left / bb_right).
- Accepts one shifted-out bit per cycle under a valid/ready handshake and reassembles the bits into a WIDTH-bit word.
- Presents each completed (or flushed partial) word on an output valid/ready handshake.
- Sits between the ALU shift unit and any consumer that needs the bits lost off the end of a shift sequence.

Parameters:
- WIDTH, 4: word width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1): width of the bit-count field; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- bit_in  input  1  serial bit, driven from bb_left or bb_right.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  collector accepts a bit this cycle.
- dir  input  1  0 = bits come from a left shift (MSB first); 1 = from a right shift (LSB first). Sampled with the first bit of each word.
- flush  input  1  terminate the current word early and present it.
- out_word  output  WIDTH  assembled word.
- out_count  output  CW  number of valid bits in out_word (1..WIDTH).
- out_dir  output  1  dir latched for this word.
- out_valid  output  1  out_word is valid.
- out_ready  input  1  consumer takes the word.
- dir_err  output  1  sticky; dir changed mid-word. Cleared only by reset.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; the shift register, out_word and out_count are 0.
  - out_valid=0, dir_err=0, bit_ready=1.
- A bit transfer occurs when bit_valid & bit_ready. A word transfer occurs when out_valid & out_ready.
- States:
  - IDLE (count=0, bit_ready=1):
    - On a bit transfer: latch dir into dir_q, insert the bit, set count=1, go to COLLECT.
    - A flush in IDLE with no bit transfer is ignored; an empty word is never emitted.
  - COLLECT (bit_ready=1):
    - Each bit transfer inserts the bit and increments count.
    - When count reaches WIDTH on that transfer, go to HOLD.
  - HOLD (bit_ready=0, out_valid=1):
    - out_word, out_count and out_dir stay stable until a word transfer.
    - On a word transfer: clear the register and count, go to IDLE.
    - No bypass: a bit cannot be accepted in the same cycle as the word transfer.
- Insertion rules:
  - dir_q=0: reg <= {reg[WIDTH-2:0], bit_in}. The first bit ends up in the MSB of a full word.
  - dir_q=1: reg <= {bit_in, reg[WIDTH-1:1]}. The first bit ends up in the LSB of a full word.
  - Partial words are not re-justified. For dir_q=0 the valid bits sit in the low out_count positions; for dir_q=1 they sit in the high positions. Unfilled positions read 0.
- Flush in COLLECT:
  - Go to HOLD with the current count; out_valid rises the next cycle.
  - Flush and a bit transfer in the same cycle: the bit is inserted first, then the word is presented with count+1.
  - If that bit completes the word, out_count=WIDTH.
- dir change mid-word: if dir != dir_q on any bit transfer in COLLECT, set dir_err. The bit is still inserted using dir_q.
- Latency: out_valid asserts on the cycle after the final bit transfer or the flush.
- Reset mid-word or in HOLD: all state is discarded immediately and nothing is emitted.
- out_count never wraps; count saturates at WIDTH by construction.

Optional Feature:
- Macro: SHIFT_COLLECTOR_PARITY_EN.
- Defined:
  - Adds output par_err (1 bit).
  - After WIDTH data bits, one extra bit is accepted in a state PARITY before HOLD.
  - par_err = XOR of the data bits XOR the parity bit (even parity expected). It is valid with out_valid.
  - A flush in COLLECT skips PARITY and forces par_err=0.
  - A flush during PARITY goes to HOLD with par_err=1.
- Not defined: no PARITY state, no par_err port; behaviour exactly as above.

Test Plan:
- dir=0, bits 1,0,1,1 on consecutive cycles, out_ready=1 -> out_word=4'b1011, out_count=4, out_valid one cycle after the 4th bit, bit_ready=0 for that cycle.
- dir=1, bits 1,0,1,1 -> out_word=4'b1101, out_dir=1.
- out_ready=0 for 5 cycles after a full word while bit_valid=1 -> bit_ready=0, out_word stable; out_ready=1 -> word transfer, back to IDLE, next bit accepted the cycle after.
- dir=0, bits 1,1 then flush alone -> out_word=4'b0011, out_count=2. Then flush in IDLE -> no out_valid.
- dir=0 bit 1, then dir=1 bit 0 -> dir_err=1 and stays 1. Then assert rst_n=0 mid-word -> out_valid=0, dir_err=0, nothing emitted.
- With SHIFT_COLLECTOR_PARITY_EN: data 1,0,1,1 then parity 1 -> par_err=0; parity 0 -> par_err=1.

Source files
------------

// File: rtl/shift_collector.sv
// Serial-to-parallel collector: gathers shifted-out bits into WIDTH-bit words with handshakes.
// Optional trailing even-parity bit and par_err output when SHIFT_COLLECTOR_PARITY_EN is defined.
module shift_collector #(
  parameter int unsigned  WIDTH = 4,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             dir,
  input  logic             flush,
  output logic [WIDTH-1:0] out_word,
  output logic [CW-1:0]    out_count,
  output logic             out_dir,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFT_COLLECTOR_PARITY_EN
  output logic             par_err,
`endif
  output logic             dir_err
);

  typedef enum logic [1:0] {StIdle, StCollect, StParity, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             dir_q, dir_d;
  logic             dir_err_q, dir_err_d;
  logic             bit_xfer, word_xfer;
`ifdef SHIFT_COLLECTOR_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  // dir=0 shifts toward the MSB (left-shift source), dir=1 toward the LSB.
  function automatic logic [WIDTH-1:0] insert_bit(input logic [WIDTH-1:0] sr, input logic b,
                                                  input logic d);
    return d ? {b, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], b};
  endfunction

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    dir_err_d = dir_err_q;
`ifdef SHIFT_COLLECTOR_PARITY_EN
    par_err_d = par_err_q;
`endif
    bit_ready = (state_q != StHold);
    out_valid = (state_q == StHold);
    bit_xfer  = bit_valid & bit_ready;
    word_xfer = out_valid & out_ready;
    cnt_inc   = cnt_q + CW'(1);

    unique case (state_q)
      StIdle: begin
        if (bit_xfer) begin
          dir_d   = dir;
          sr_d    = insert_bit(sr_q, bit_in, dir);
          cnt_d   = CW'(1);
          state_d = flush ? StHold : StCollect;
`ifdef SHIFT_COLLECTOR_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      StCollect: begin
        if (bit_xfer) begin
          if (dir != dir_q) dir_err_d = 1'b1;
          // A mismatching dir is flagged but the word keeps its original orientation.
          sr_d  = insert_bit(sr_q, bit_in, dir_q);
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(WIDTH)) begin
`ifdef SHIFT_COLLECTOR_PARITY_EN
            state_d = flush ? StHold : StParity;
`else
            state_d = StHold;
`endif
          end else if (flush) begin
            state_d = StHold;
          end
        end else if (flush) begin
          state_d = StHold;
        end
`ifdef SHIFT_COLLECTOR_PARITY_EN
        par_err_d = 1'b0;
`endif
      end
`ifdef SHIFT_COLLECTOR_PARITY_EN
      StParity: begin
        if (bit_xfer) begin
          par_err_d = (^sr_q) ^ bit_in;
          state_d   = StHold;
        end else if (flush) begin
          par_err_d = 1'b1;
          state_d   = StHold;
        end
      end
`endif
      StHold: begin
        if (word_xfer) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = StIdle;
`ifdef SHIFT_COLLECTOR_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      dir_err_q <= 1'b0;
`ifdef SHIFT_COLLECTOR_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      dir_err_q <= dir_err_d;
`ifdef SHIFT_COLLECTOR_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign out_word  = sr_q;
  assign out_count = cnt_q;
  assign out_dir   = dir_q;
  assign dir_err   = dir_err_q;
`ifdef SHIFT_COLLECTOR_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule
